// File: rtl/mem_stage_pipe_if.sv
// EX/MEM input and MEM/WB output bundle of the MEM stage.
// The master side is the pipeline around the stage; the slave side is mem_stage_pipe.
interface mem_stage_pipe_if #(
    parameter int IR_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [IR_W-1:0] in_ir;
    logic [31:0]     in_alu_out;
    logic [31:0]     in_store_data;
    logic            in_mem_read;
    logic            in_mem_write;
    logic            in_reg_write;
    logic [2:0]      in_funct3;

    logic            out_valid;
    logic            out_ready;
    logic [IR_W-1:0] out_ir;
    logic [31:0]     out_alu_out;
    logic [31:0]     out_load_data;
    logic            out_mem_read;
    logic            out_reg_write;
    logic            out_misalign;

    modport master (
        output in_valid, in_ir, in_alu_out, in_store_data,
               in_mem_read, in_mem_write, in_reg_write, in_funct3,
        input  in_ready,
        input  out_valid, out_ir, out_alu_out, out_load_data,
               out_mem_read, out_reg_write, out_misalign,
        output out_ready
    );

    modport slave (
        input  in_valid, in_ir, in_alu_out, in_store_data,
               in_mem_read, in_mem_write, in_reg_write, in_funct3,
        output in_ready,
        output out_valid, out_ir, out_alu_out, out_load_data,
               out_mem_read, out_reg_write, out_misalign,
        input  out_ready
    );
endinterface

// File: rtl/mem_stage_pipe.sv
// MEM stage: data memory with byte/half/word loads and stores, latency FSM and MEM/WB register.
// Optional MEM_STAGE_MISALIGN_TRAP_EN flags misaligned accesses instead of force-aligning them.
module mem_stage_pipe #(
    parameter int DMEM_DEPTH  = 2048,
    parameter int MEM_LATENCY = 1,
    parameter int IR_W        = 32,
    localparam int AW         = $clog2(DMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    mem_stage_pipe_if.slave bus,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   dbg_data
);
    typedef enum logic [0:0] {IDLE, BUSY} state_t;

    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

    state_t          state, next_state;
    logic [CW-1:0]   cnt, cnt_next;
    logic [31:0]     dmem [DMEM_DEPTH];

    logic            accept, is_mem, is_load, is_store, misalign;
    logic            load_direct, load_pend;
    logic [AW-1:0]   word_idx;
    logic [1:0]      lane;
    logic [31:0]     rd_word, shifted, ext_data, load_data, wdata;
    logic [3:0]      wstrb;
    logic            reg_write_eff;

    logic [IR_W-1:0] pend_ir;
    logic [31:0]     pend_alu, pend_ld;
    logic            pend_mrd, pend_rw, pend_mis;

    assign is_mem   = bus.in_mem_read | bus.in_mem_write;
    assign is_store = bus.in_mem_write;
    assign is_load  = bus.in_mem_read & ~bus.in_mem_write;

    assign bus.in_ready = ~reset & (state == IDLE) & (~bus.out_valid | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    assign word_idx = bus.in_alu_out[AW+1:2];
    assign rd_word  = dmem[word_idx];
    assign dbg_data = dmem[dbg_addr];

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        if (is_mem) begin
            if (bus.in_funct3 == 3'b010)
                misalign = |bus.in_alu_out[1:0];
            else if (bus.in_funct3 == 3'b001 || (is_load && bus.in_funct3 == 3'b101))
                misalign = bus.in_alu_out[0];
        end
    end
    assign lane = bus.in_alu_out[1:0];
`else
    assign misalign = 1'b0;
    // Without the trap, halves and words silently snap to their natural alignment.
    always_comb begin
        lane = bus.in_alu_out[1:0];
        case (bus.in_funct3[1:0])
            2'b01:   lane[0] = 1'b0;
            2'b10:   lane    = 2'b00;
            default: ;
        endcase
    end
`endif

    assign shifted = rd_word >> {lane, 3'b000};

    always_comb begin
        ext_data = '0;
        case (bus.in_funct3)
            3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  ext_data = rd_word;
            3'b100:  ext_data = {24'h0, shifted[7:0]};
            3'b101:  ext_data = {16'h0, shifted[15:0]};
            default: ext_data = '0;
        endcase
    end

    assign load_data     = (is_load & ~misalign) ? ext_data : 32'h0;
    assign reg_write_eff = bus.in_reg_write & ~misalign;

    always_comb begin
        wstrb = 4'b0000;
        wdata = bus.in_store_data;
        case (bus.in_funct3)
            3'b000: begin
                wstrb = 4'b0001 << lane;
                wdata = {4{bus.in_store_data[7:0]}};
            end
            3'b001: begin
                wstrb = 4'b0011 << {lane[1], 1'b0};
                wdata = {2{bus.in_store_data[15:0]}};
            end
            3'b010:  wstrb = 4'b1111;
            default: wstrb = 4'b0000;
        endcase
        if (!(accept && is_store) || misalign)
            wstrb = 4'b0000;
    end

    // Stores commit on the accepting edge so a following load already sees them.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (wstrb[b])
                dmem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
    end

    always_comb begin
        next_state  = state;
        cnt_next    = cnt;
        load_direct = 1'b0;
        load_pend   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mem && MEM_LATENCY > 1) begin
                        next_state = BUSY;
                        cnt_next   = CNT_INIT;
                    end else begin
                        load_direct = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    load_pend  = 1'b1;
                    next_state = IDLE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pend_ir  <= bus.in_ir;
            pend_alu <= bus.in_alu_out;
            pend_ld  <= load_data;
            pend_mrd <= bus.in_mem_read;
            pend_rw  <= reg_write_eff;
            pend_mis <= misalign;
        end
    end

    // BUSY is only entered with an empty MEM/WB register, so the pending load never overwrites.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid     <= 1'b0;
            bus.out_ir        <= '0;
            bus.out_alu_out   <= '0;
            bus.out_load_data <= '0;
            bus.out_mem_read  <= 1'b0;
            bus.out_reg_write <= 1'b0;
            bus.out_misalign  <= 1'b0;
        end else if (load_direct) begin
            bus.out_valid     <= 1'b1;
            bus.out_ir        <= bus.in_ir;
            bus.out_alu_out   <= bus.in_alu_out;
            bus.out_load_data <= load_data;
            bus.out_mem_read  <= bus.in_mem_read;
            bus.out_reg_write <= reg_write_eff;
            bus.out_misalign  <= misalign;
        end else if (load_pend) begin
            bus.out_valid     <= 1'b1;
            bus.out_ir        <= pend_ir;
            bus.out_alu_out   <= pend_alu;
            bus.out_load_data <= pend_ld;
            bus.out_mem_read  <= pend_mrd;
            bus.out_reg_write <= pend_rw;
            bus.out_misalign  <= pend_mis;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: a latency-1 instance for data paths and throughput,
// a latency-3 instance for BUSY timing, backpressure and reset abort.
module tb_mem_stage_pipe;
    typedef struct {
        logic [2:0]  f3;
        logic        rd;
        logic        wr;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] exp_ld;
        logic        exp_rw;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] alu;
        logic [31:0] ld;
        logic        mrd;
        logic        rw;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] dbg_addr1, dbg_addr3;
    logic [31:0] dbg_data1, dbg_data3;

    int total_checks  = 0;
    int passed_checks = 0;
    int last_wait     = 0;
    int run1          = 0;
    int max_run1      = 0;

    exp_t q1[$];
    exp_t q3[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    mem_stage_pipe_if #(.IR_W(32)) bus1 ();
    mem_stage_pipe_if #(.IR_W(32)) bus3 ();

    mem_stage_pipe #(.DMEM_DEPTH(2048), .MEM_LATENCY(1), .IR_W(32)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .dbg_addr(dbg_addr1), .dbg_data(dbg_data1)
    );

    mem_stage_pipe #(.DMEM_DEPTH(2048), .MEM_LATENCY(3), .IR_W(32)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3), .dbg_addr(dbg_addr3), .dbg_data(dbg_data3)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual === expected)
            passed_checks++;
        else
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic rd, input logic wr, input logic rw,
                                input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] exp_ld, input logic exp_rw, input logic exp_mis);
        vec_t v;
        v.f3 = f3; v.rd = rd; v.wr = wr; v.rw = rw; v.addr = addr; v.sdata = sdata;
        v.exp_ld = exp_ld; v.exp_rw = exp_rw; v.exp_mis = exp_mis;
        return v;
    endfunction

    task automatic compare_entry(input string tag, input exp_t e, input logic [31:0] ir, input logic [31:0] alu,
                                 input logic [31:0] ld, input logic mrd, input logic rw, input logic mis);
        checkOutput($sformatf("%s ir", tag), ir, e.ir);
        checkOutput($sformatf("%s ir=%0h alu_out", tag, e.ir), alu, e.alu);
        checkOutput($sformatf("%s ir=%0h load_data", tag, e.ir), ld, e.ld);
        checkOutput($sformatf("%s ir=%0h flags{mrd,rw,mis}", tag, e.ir),
                    {29'h0, mrd, rw, mis}, {29'h0, e.mrd, e.rw, e.mis});
    endtask

    // Scoreboards: every consumed MEM/WB entry must match the oldest accepted stimulus.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (!reset && bus1.out_valid) begin
            run1++;
            if (run1 > max_run1) max_run1 = run1;
        end else begin
            run1 = 0;
        end
        if (!reset && bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) begin
                checkOutput("dut1 unexpected out_valid", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                compare_entry("dut1", e, bus1.out_ir, bus1.out_alu_out, bus1.out_load_data,
                              bus1.out_mem_read, bus1.out_reg_write, bus1.out_misalign);
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (!reset && bus3.out_valid && bus3.out_ready) begin
            if (q3.size() == 0) begin
                checkOutput("dut3 unexpected out_valid", 32'd1, 32'd0);
            end else begin
                e = q3.pop_front();
                compare_entry("dut3", e, bus3.out_ir, bus3.out_alu_out, bus3.out_load_data,
                              bus3.out_mem_read, bus3.out_reg_write, bus3.out_misalign);
            end
        end
    end

    task automatic drive_bus(input int sel, input vec_t v, input logic [31:0] ir, input logic valid);
        if (sel == 1) begin
            bus1.in_valid = valid; bus1.in_ir = ir; bus1.in_alu_out = v.addr;
            bus1.in_store_data = v.sdata; bus1.in_mem_read = v.rd; bus1.in_mem_write = v.wr;
            bus1.in_reg_write = v.rw; bus1.in_funct3 = v.f3;
        end else begin
            bus3.in_valid = valid; bus3.in_ir = ir; bus3.in_alu_out = v.addr;
            bus3.in_store_data = v.sdata; bus3.in_mem_read = v.rd; bus3.in_mem_write = v.wr;
            bus3.in_reg_write = v.rw; bus3.in_funct3 = v.f3;
        end
    endtask

    task automatic drop_valid(input int sel);
        if (sel == 1) bus1.in_valid = 1'b0;
        else          bus3.in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Entered and left 2 time units after a rising edge; on return the entry was accepted at the last edge.
    task automatic applyStimulus(input int sel, input vec_t v, input logic [31:0] ir, input bit push);
        exp_t e;
        bit   accepted = 1'b0;
        int   waited   = 0;
        drive_bus(sel, v, ir, 1'b1);
        for (int k = 0; k < 20; k++) begin
            #1;
            if ((sel == 1) ? bus1.in_ready : bus3.in_ready) begin
                accepted = 1'b1;
                break;
            end
            step();
            waited++;
        end
        if (!accepted) begin
            checkOutput("accept timeout", 32'd0, 32'd1);
        end else begin
            e.ir = ir; e.alu = v.addr; e.ld = v.exp_ld; e.mrd = v.rd; e.rw = v.exp_rw; e.mis = v.exp_mis;
            if (push) begin
                if (sel == 1) q1.push_back(e);
                else          q3.push_back(e);
            end
            step();
        end
        last_wait = waited;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t alu_op;
        int   stalls;

        //          f3      rd    wr    rw    addr          sdata         exp_ld        rw    mis
        vecs.push_back(mk(3'b010, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h8000_00F0, 32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(3'b000, 1'b1, 1'b0, 1'b1, 32'h0000_0023, 32'h0,        32'hFFFF_FF80, 1'b1, 1'b0));
        vecs.push_back(mk(3'b100, 1'b1, 1'b0, 1'b1, 32'h0000_0023, 32'h0,        32'h0000_0080, 1'b1, 1'b0));
        vecs.push_back(mk(3'b001, 1'b1, 1'b0, 1'b1, 32'h0000_0022, 32'h0,        32'hFFFF_8000, 1'b1, 1'b0));
        vecs.push_back(mk(3'b010, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0,        32'h8000_00F0, 1'b1, 1'b0));
        vecs.push_back(mk(3'b010, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h1122_3344, 32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(3'b000, 1'b0, 1'b1, 1'b0, 32'h0000_0041, 32'h1234_56AA, 32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(3'b001, 1'b0, 1'b1, 1'b0, 32'h0000_0042, 32'h5555_BEEF, 32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(3'b010, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0,        32'hBEEF_AA44, 1'b1, 1'b0));
        vecs.push_back(mk(3'b101, 1'b1, 1'b0, 1'b1, 32'h0000_0042, 32'h0,        32'h0000_BEEF, 1'b1, 1'b0));
        vecs.push_back(mk(3'b001, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0,        32'hFFFF_AA44, 1'b1, 1'b0));
        vecs.push_back(mk(3'b000, 1'b1, 1'b0, 1'b1, 32'h0000_0041, 32'h0,        32'hFFFF_FFAA, 1'b1, 1'b0));
        vecs.push_back(mk(3'b100, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0,        32'h0000_0044, 1'b1, 1'b0));
        vecs.push_back(mk(3'b000, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0,        32'h0,        1'b1, 1'b0));
        vecs.push_back(mk(3'b011, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0,        32'h0,        1'b1, 1'b0));
        vecs.push_back(mk(3'b011, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(3'b010, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0,        32'hBEEF_AA44, 1'b1, 1'b0));
        vecs.push_back(mk(3'b010, 1'b0, 1'b1, 1'b0, 32'h0000_2060, 32'hCAFE_BABE, 32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(3'b010, 1'b1, 1'b0, 1'b1, 32'h0000_0060, 32'h0,        32'hCAFE_BABE, 1'b1, 1'b0));
        vecs.push_back(mk(3'b010, 1'b1, 1'b1, 1'b0, 32'h0000_0064, 32'h0BAD_F00D, 32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(3'b010, 1'b1, 1'b0, 1'b1, 32'h0000_0064, 32'h0,        32'h0BAD_F00D, 1'b1, 1'b0));
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        vecs.push_back(mk(3'b010, 1'b0, 1'b1, 1'b0, 32'h0000_0022, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b1));
        vecs.push_back(mk(3'b010, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0,        32'h8000_00F0, 1'b1, 1'b0));
        vecs.push_back(mk(3'b010, 1'b1, 1'b0, 1'b1, 32'h0000_0022, 32'h0,        32'h0,        1'b0, 1'b1));
        vecs.push_back(mk(3'b001, 1'b1, 1'b0, 1'b1, 32'h0000_0023, 32'h0,        32'h0,        1'b0, 1'b1));
`else
        vecs.push_back(mk(3'b010, 1'b0, 1'b1, 1'b0, 32'h0000_0022, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(3'b010, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0,        32'hDEAD_BEEF, 1'b1, 1'b0));
        vecs.push_back(mk(3'b010, 1'b1, 1'b0, 1'b1, 32'h0000_0022, 32'h0,        32'hDEAD_BEEF, 1'b1, 1'b0));
        vecs.push_back(mk(3'b001, 1'b1, 1'b0, 1'b1, 32'h0000_0023, 32'h0,        32'hFFFF_DEAD, 1'b1, 1'b0));
`endif
        alu_op = mk(3'b000, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        reset = 1'b1;
        dbg_addr1 = '0;
        dbg_addr3 = '0;
        drive_bus(1, alu_op, 32'h0, 1'b0);
        drive_bus(3, alu_op, 32'h0, 1'b0);
        bus1.out_ready = 1'b1;
        bus3.out_ready = 1'b1;
        bus1.in_valid  = 1'b1;
        bus3.in_valid  = 1'b1;
        step();
        step();
        #1;
        $display("[TB] reset checks");
        checkOutput("in_ready during reset dut1", {31'h0, bus1.in_ready}, 32'h0);
        checkOutput("in_ready during reset dut3", {31'h0, bus3.in_ready}, 32'h0);
        checkOutput("out_valid after reset dut1", {31'h0, bus1.out_valid}, 32'h0);
        checkOutput("out_load_data after reset dut3", bus3.out_load_data, 32'h0);
        drop_valid(1);
        drop_valid(3);
        reset = 1'b0;
        step();

        $display("[TB] table vectors on latency-1 instance");
        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(1, vecs[i], 32'h1000 + i, 1'b1);
        drop_valid(1);
        repeat (3) step();
        dbg_addr1 = 11'd16;
        #1;
        checkOutput("dbg_data word 16", dbg_data1, 32'hBEEF_AA44);
        dbg_addr1 = 11'd8;
        #1;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        checkOutput("dbg_data word 8 after trapped store", dbg_data1, 32'h8000_00F0);
`else
        checkOutput("dbg_data word 8 after aligned store", dbg_data1, 32'hDEAD_BEEF);
`endif

        $display("[TB] throughput burst");
        max_run1 = 0;
        stalls   = 0;
        for (int i = 0; i < 8; i++) begin
            alu_op.addr = 32'h100 + i;
            applyStimulus(1, alu_op, 32'h2000 + i, 1'b1);
            stalls += last_wait;
        end
        drop_valid(1);
        repeat (3) step();
        checkOutput("throughput stall cycles", stalls, 32'd0);
        checkOutput("throughput consecutive out_valid", max_run1, 32'd8);

        $display("[TB] latency-3 store, then reset during BUSY");
        applyStimulus(3, mk(3'b010, 1'b0, 1'b1, 1'b0, 32'h30, 32'h5A5A_1234, 32'h0, 1'b0, 1'b0), 32'h3000, 1'b1);
        drop_valid(3);
        repeat (4) step();
        applyStimulus(3, mk(3'b010, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0), 32'h3001, 1'b0);
        drop_valid(3);
        reset = 1'b1;
        #1;
        checkOutput("in_ready while reset held", {31'h0, bus3.in_ready}, 32'h0);
        step();
        #1;
        checkOutput("out_valid during reset", {31'h0, bus3.out_valid}, 32'h0);
        checkOutput("in_ready during reset 2nd cycle", {31'h0, bus3.in_ready}, 32'h0);
        step();
        reset = 1'b0;
        #1;
        checkOutput("in_ready after reset release", {31'h0, bus3.in_ready}, 32'h1);
        checkOutput("out_valid after reset release", {31'h0, bus3.out_valid}, 32'h0);
        step();
        #1;
        checkOutput("aborted load produces no entry", {31'h0, bus3.out_valid}, 32'h0);
        step();

        $display("[TB] latency and backpressure");
        bus3.out_ready = 1'b0;
        applyStimulus(3, mk(3'b010, 1'b1, 1'b0, 1'b1, 32'h30, 32'h0, 32'h5A5A_1234, 1'b1, 1'b0), 32'h3002, 1'b1);
        drop_valid(3);
        #1;
        checkOutput("T+1 in_ready", {31'h0, bus3.in_ready}, 32'h0);
        checkOutput("T+1 out_valid", {31'h0, bus3.out_valid}, 32'h0);
        step();
        #1;
        checkOutput("T+2 in_ready", {31'h0, bus3.in_ready}, 32'h0);
        checkOutput("T+2 out_valid", {31'h0, bus3.out_valid}, 32'h0);
        step();
        #1;
        checkOutput("T+3 out_valid", {31'h0, bus3.out_valid}, 32'h1);
        for (int c = 0; c < 4; c++) begin
            step();
            #1;
            checkOutput($sformatf("stall %0d out_valid", c), {31'h0, bus3.out_valid}, 32'h1);
            checkOutput($sformatf("stall %0d out_load_data", c), bus3.out_load_data, 32'h5A5A_1234);
            checkOutput($sformatf("stall %0d in_ready", c), {31'h0, bus3.in_ready}, 32'h0);
        end
        step();
        bus3.out_ready = 1'b1;
        repeat (2) step();

        $display("[TB] latency-3 ALU op is single cycle");
        alu_op.addr = 32'h0000_0777;
        applyStimulus(3, alu_op, 32'h3003, 1'b1);
        drop_valid(3);
        #1;
        checkOutput("ALU op on latency-3 out_valid", {31'h0, bus3.out_valid}, 32'h1);
        repeat (3) step();

        checkOutput("dut1 scoreboard drained", q1.size(), 32'd0);
        checkOutput("dut3 scoreboard drained", q3.size(), 32'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
- Parametrised MEM pipeline stage for the 5-stage core.
- Owns the data memory and performs byte, half and word loads and stores (RISC-V funct3 encoding), with sign/zero extension.
- Models configurable memory access latency with a valid/ready handshake on both sides.
- Drives a single-entry MEM/WB register that feeds writeback.

Parameters:
- DMEM_DEPTH, 2048: number of 32-bit words in data memory; power of 2, at least 4.
- MEM_LATENCY, 1: cycles from acceptance of a load/store to its MEM/WB result; at least 1.
- IR_W, 32: width of the instruction word carried down the pipe.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: EX/MEM entry is valid.
- in_ready, output, 1: stage accepts the entry this cycle.
- in_ir, input, IR_W: instruction word.
- in_alu_out, input, 32: ALU result; this is the byte address for memory ops.
- in_store_data, input, 32: store data (rs2).
- in_mem_read, input, 1: load instruction.
- in_mem_write, input, 1: store instruction.
- in_reg_write, input, 1: instruction writes rd.
- in_funct3, input, 3: access size and sign.
- out_valid, output, 1: MEM/WB entry valid.
- out_ready, input, 1: writeback consumes the entry.
- out_ir, output, IR_W: registered instruction word.
- out_alu_out, output, 32: registered ALU result.
- out_load_data, output, 32: extended load data; 0 for non-loads.
- out_mem_read, output, 1: registered in_mem_read.
- out_reg_write, output, 1: registered in_reg_write, possibly squashed (see below).
- out_misalign, output, 1: misaligned access flag.
- dbg_addr, input, clog2(DMEM_DEPTH): word index for the debug peek.
- dbg_data, output, 32: combinational read of dmem[dbg_addr].

Behaviour:
- Reset: all outputs 0, out_valid 0, FSM to IDLE, latency counter 0. Data memory contents are not reset. in_ready is 0 while reset is high.
- Accept condition: accept = in_valid & in_ready.
  - in_ready = (state==IDLE) & (!out_valid | out_ready).
- Addressing: word index = in_alu_out[clog2(DMEM_DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DMEM_DEPTH bytes.
- Stores: commit to memory on the accepting edge.
  - SB (funct3 000) writes 1 byte lane selected by addr[1:0].
  - SH (001) writes 2 lanes selected by addr[1].
  - SW (010) writes all 4 lanes.
  - Any other funct3 on a store: no write, entry still retires.
- Loads: word is read on the accepting edge, lane-selected and extended.
  - LB 000: sign-extended byte.
  - LH 001: sign-extended half.
  - LW 010: full word.
  - LBU 100: zero-extended byte.
  - LHU 101: zero-extended half.
  - Other funct3: load data 0.
- in_mem_read and in_mem_write both high: treated as a store; out_mem_read still reflects the input.
- FSM states: IDLE, BUSY.
  - Non-memory op, or any op when MEM_LATENCY=1: entry accepted at edge T, out_valid=1 after edge T; FSM stays IDLE.
  - Memory op with MEM_LATENCY>1: go to BUSY with cnt=MEM_LATENCY-2. cnt decrements each cycle. At cnt==0 the next edge loads MEM/WB and returns to IDLE.
  - Result visible after edge T+MEM_LATENCY-1 (first valid cycle T+MEM_LATENCY). in_ready=0 throughout BUSY.
- MEM/WB register:
  - Holds its value while out_valid & !out_ready.
  - out_valid clears on a consume edge unless a new entry loads on the same edge. Back-to-back consume+load is allowed (full throughput when MEM_LATENCY=1).
- Reset during BUSY: the op is aborted and no MEM/WB entry is produced. A store accepted before reset remains committed.
- Same-address load after store: the load observes the new data, because the store committed at an earlier edge.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, sets out_misalign=1 for that entry.
  - The store is suppressed, out_load_data=0 and out_reg_write=0.
  - Latency is unchanged.
- Undefined: low address bits are forced to natural alignment (half: bit0=0; word: bits1:0=0), and out_misalign is tied 0.

Test Plan:
- Reset: hold reset 2 cycles mid-BUSY (MEM_LATENCY=3) after a load to 0x10 -> out_valid stays 0, in_ready=0 during reset, and in_ready=1 the cycle after reset deasserts.
- Store/load sizes: SW 0x8000_00F0 @0x20; LB @0x23 -> 0xFFFF_FF80; LBU @0x23 -> 0x0000_0080; LH @0x22 -> 0xFFFF_8000; LW @0x20 -> 0x8000_00F0.
- Byte lanes: SW 0x1122_3344 @0x40, SB 0xAA @0x41, SH 0xBEEF @0x42 -> LW @0x40 = 0xBEEF_AA44; dbg_addr=16 gives the same value.
- Latency/backpressure: MEM_LATENCY=3, load accepted at cycle T -> in_ready=0 at T+1 and T+2, out_valid first at T+3. With out_ready=0 for 4 cycles, the output is held stable and in_ready=0.
- Throughput: MEM_LATENCY=1, 8 back-to-back ALU ops with out_ready=1 -> 8 consecutive out_valid cycles, out_ir in order.
- Misalign: SW @0x22 -> with MEM_STAGE_MISALIGN_TRAP_EN: out_misalign=1, word 0x20 unchanged, out_reg_write=0. Without it: the store writes word 0x20.
